// File: rtl/timer_pkg.sv
// Shared types and BCD limits for the keypad countdown timer.
package timer_pkg;
  localparam int BCD_W = 4;
  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t MAX_MIN = 4'd9;
  localparam bcd_t MAX_DEZ = 4'd5;
  localparam bcd_t MAX_UNI = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  // Caller guarantees exactly one bit set.
  function automatic bcd_t onehot_to_bcd(input logic [9:0] keys);
    bcd_t v;
    v = '0;
    for (int i = 0; i < 10; i++) begin
      if (keys[i]) v = bcd_t'(i);
    end
    return v;
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// Debounces a one-hot keypad and emits one registered BCD strobe per press;
// a new press is only armed after the keypad has been idle for the same stable time.
module keypad_debounce
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] Keypad,
  output logic       DigitValid,
  output bcd_t       Digit
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [9:0]    pat_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wait_rel_q, wait_rel_d;
  logic          vld_q, vld_d;
  bcd_t          dig_q, dig_d;

  logic key_zero, key_onehot, key_same, stable_hit;

  assign key_zero   = (Keypad == 10'd0);
  assign key_onehot = $onehot(Keypad);
  assign key_same   = (Keypad == pat_q);
  // Fires on the single cycle the pattern reaches the required stable length.
  assign stable_hit = key_same && (cnt_q == CNT_MAX - 1'b1);

  always_comb begin
    cnt_d      = cnt_q;
    wait_rel_d = wait_rel_q;
    vld_d      = 1'b0;
    dig_d      = dig_q;
    if (!key_zero && !key_onehot)  cnt_d = '0;
    else if (!key_same)            cnt_d = CW'(1);
    else if (cnt_q != CNT_MAX)     cnt_d = cnt_q + 1'b1;

    if (stable_hit && key_onehot && !wait_rel_q) begin
      vld_d      = 1'b1;
      dig_d      = onehot_to_bcd(Keypad);
      wait_rel_d = 1'b1;
    end else if (stable_hit && key_zero) begin
      wait_rel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q      <= '0;
      cnt_q      <= '0;
      wait_rel_q <= 1'b0;
      vld_q      <= 1'b0;
      dig_q      <= '0;
    end else begin
      pat_q      <= Keypad;
      cnt_q      <= cnt_d;
      wait_rel_q <= wait_rel_d;
      vld_q      <= vld_d;
      dig_q      <= dig_d;
    end
  end

  assign DigitValid = vld_q;
  assign Digit      = dig_q;
endmodule

// File: rtl/keypad_timer_encoder.sv
// M:SS entry from a debounced keypad and 1 Hz countdown to 0:00; all outputs registered.
// Pulse priority: Clear > Stop > Start > Tick > digit.
module keypad_timer_encoder
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] Keypad,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clear,
  input  logic       Tick,
  output logic [3:0] Minutos,
  output logic [3:0] DezenaSeg,
  output logic [3:0] UnidadeSeg,
  output logic       Running,
  output logic       Done
);
  logic   dig_vld;
  bcd_t   dig;
  state_e state_q;
  bcd_t   min_q, dez_q, uni_q;
  logic   run_q, done_q;

  keypad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .Keypad     (Keypad),
    .DigitValid (dig_vld),
    .Digit      (dig)
  );

  bcd_t dec_min, dec_dez, dec_uni;
  logic time_zero, last_sec;

  always_comb begin
    dec_min = min_q;
    dec_dez = dez_q;
    dec_uni = uni_q;
    if (uni_q != 4'd0) begin
      dec_uni = uni_q - 4'd1;
    end else begin
      dec_uni = MAX_UNI;
      if (dez_q != 4'd0) begin
        dec_dez = dez_q - 4'd1;
      end else begin
        dec_dez = MAX_DEZ;
        dec_min = min_q - 4'd1;
      end
    end
  end

  assign time_zero = (min_q == 4'd0) && (dez_q == 4'd0) && (uni_q == 4'd0);
  assign last_sec  = (min_q == 4'd0) && (dez_q == 4'd0) && (uni_q == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      min_q   <= '0;
      dez_q   <= '0;
      uni_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (Clear) begin
      state_q <= IDLE;
      min_q   <= '0;
      dez_q   <= '0;
      uni_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start && !time_zero) begin
            state_q <= RUN;
            run_q   <= 1'b1;
          end else if (dig_vld && uni_q <= MAX_DEZ) begin
            // Guard keeps the shifted tens-of-seconds digit within 0-5.
            min_q <= dez_q;
            dez_q <= uni_q;
            uni_q <= dig;
          end
        end
        RUN: begin
          if (Stop) begin
            state_q <= PAUSE;
            run_q   <= 1'b0;
          end else if (Tick) begin
            min_q <= dec_min;
            dez_q <= dec_dez;
            uni_q <= dec_uni;
            if (last_sec) begin
              state_q <= DONE;
              run_q   <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (Start) begin
            state_q <= RUN;
            run_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Minutos    = min_q;
  assign DezenaSeg  = dez_q;
  assign UnidadeSeg = uni_q;
  assign Running    = run_q;
  assign Done       = done_q;
endmodule
